// File: rtl/term_writer_if.sv
// Character stream in, vram write port out, for the text-terminal write engine.
// Handshake: a character transfers on a clk edge where in_valid & in_ready are both high;
// while in_valid is high and in_ready low, in_char must stay stable. write_ce is never high while vram_busy.
interface term_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       vram_busy;
  logic       write_ce;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_char;

  modport master (
    output in_valid, in_char, vram_busy,
    input  in_ready, write_ce, write_row, write_col, write_char
  );

  modport slave (
    input  in_valid, in_char, vram_busy,
    output in_ready, write_ce, write_row, write_col, write_char
  );
endinterface

// File: rtl/term_writer.sv
// Text-terminal write engine: decodes characters, moves the cursor, wraps and scrolls,
// and writes vram only in cycles the display reader leaves idle.
module term_writer #(
  parameter int         COLS  = 100,
  parameter int         ROWS  = 30,
  parameter int         TAB_W = 8,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic         clk,
  input  logic         reset,
  term_writer_if.slave bus,
  output logic [4:0]   top_row,
  output logic [4:0]   cursor_row,
  output logic [6:0]   cursor_col,
  output logic [1:0]   o_dbg_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [7:0] COLS_W   = 8'(COLS);
  localparam logic [7:0] TAB_MASK = 8'(TAB_W - 1);

  logic [1:0] r_state;
  logic [4:0] r_top_row;
  logic [4:0] r_cursor_row;
  logic [6:0] r_cursor_col;
  logic [4:0] r_wr_row;
  logic [6:0] r_wr_col;
  logic [7:0] r_wr_char;
  logic [4:0] r_clr_rem;

  logic [4:0] w_phys_row;
  logic [4:0] w_top_inc;
  logic [4:0] w_clr_row_inc;
  logic [7:0] w_tab_next;
  logic       w_printable;
  logic       w_scroll;

  // Row arithmetic wraps at ROWS, not at the 5-bit width.
  function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return 5'(s);
  endfunction

  assign w_phys_row    = row_add(r_top_row, r_cursor_row);
  assign w_top_inc     = row_add(r_top_row, 5'd1);
  assign w_clr_row_inc = row_add(r_wr_row, 5'd1);
  assign w_tab_next    = ({1'b0, r_cursor_col} | TAB_MASK) + 8'd1;
  assign w_printable   = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
  assign w_scroll      = (r_cursor_row == LAST_ROW);

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.write_ce   = (r_state != S_IDLE) && !bus.vram_busy;
  assign bus.write_row  = r_wr_row;
  assign bus.write_col  = r_wr_col;
  assign bus.write_char = r_wr_char;
  assign top_row        = r_top_row;
  assign cursor_row     = r_cursor_row;
  assign cursor_col     = r_cursor_col;
  assign o_dbg_state    = r_state;

  // On the bottom line the old top row becomes the new bottom row and is blanked.
  task automatic do_newline();
    r_cursor_col <= 7'd0;
    if (!w_scroll) begin
      r_cursor_row <= r_cursor_row + 5'd1;
    end else begin
      r_top_row <= w_top_inc;
      r_wr_row  <= r_top_row;
      r_wr_col  <= 7'd0;
      r_wr_char <= BLANK;
      r_clr_rem <= 5'd0;
      r_state   <= S_CLEAR;
    end
  endtask

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_top_row    <= 5'd0;
      r_cursor_row <= 5'd0;
      r_cursor_col <= 7'd0;
      r_wr_row     <= 5'd0;
      r_wr_col     <= 7'd0;
      r_wr_char    <= 8'd0;
      r_clr_rem    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_printable) begin
              r_wr_row  <= w_phys_row;
              r_wr_col  <= r_cursor_col;
              r_wr_char <= bus.in_char;
              r_state   <= S_WRITE;
            end else if (bus.in_char == 8'h0D) begin
              r_cursor_col <= 7'd0;
            end else if (bus.in_char == 8'h0A) begin
              do_newline();
            end else if (bus.in_char == 8'h08) begin
              if (r_cursor_col != 7'd0) r_cursor_col <= r_cursor_col - 7'd1;
            end else if (bus.in_char == 8'h09) begin
              if (w_tab_next >= COLS_W) do_newline();
              else r_cursor_col <= 7'(w_tab_next);
            end else if (bus.in_char == 8'h0C) begin
              r_top_row    <= 5'd0;
              r_cursor_row <= 5'd0;
              r_cursor_col <= 7'd0;
              r_wr_row     <= 5'd0;
              r_wr_col     <= 7'd0;
              r_wr_char    <= BLANK;
              r_clr_rem    <= LAST_ROW;
              r_state      <= S_CLEAR;
            end
          end
        end
        S_WRITE: begin
          if (!bus.vram_busy) begin
            r_state <= S_IDLE;
            if (r_cursor_col == LAST_COL) do_newline();
            else r_cursor_col <= r_cursor_col + 7'd1;
          end
        end
        S_CLEAR: begin
          if (!bus.vram_busy) begin
            if (r_wr_col != LAST_COL) begin
              r_wr_col <= r_wr_col + 7'd1;
            end else if (r_clr_rem == 5'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_wr_row  <= w_clr_row_inc;
              r_wr_col  <= 7'd0;
              r_clr_rem <= r_clr_rem - 5'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: each task drives one scenario and checks its own results.
module tb_term_writer;
  localparam int COLS = 100;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] top_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;
  logic [1:0] dbg_state;

  int passes = 0;
  int checks = 0;
  int busy_viol = 0;

  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];

  term_writer_if bus();

  term_writer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(8), .BLANK(8'h20)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .top_row(top_row), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor feeding the scoreboard
  always @(negedge clk) begin
    if (bus.write_ce === 1'b1) begin
      obs_q.push_back({bus.write_row, bus.write_col, bus.write_char});
      if (bus.vram_busy) busy_viol++;
    end
  end

  // driver tasks (called at posedge+#1, return at posedge+#1)
  task automatic send_char(input logic [7:0] c);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (!acc && n < 6000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) $display("FAIL send_accept: char %h not accepted, want accept within 6000 cycles", c);
    else passes++;
  endtask

  task automatic wait_idle(input int budget, input bit pattern, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < budget) begin
      bus.vram_busy = pattern ? (n % 3 == 0) : 1'b0;
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.vram_busy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else passes++;
    checks++; if (bus.write_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", bus.write_ce); else passes++;
    checks++; if (top_row !== 5'd0) $display("FAIL reset_top: got %0d want 0", top_row); else passes++;
    checks++; if ({cursor_row, cursor_col} !== 12'd0) $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); else passes++;
    checks++; if ({bus.write_row, bus.write_col, bus.write_char} !== 20'd0) $display("FAIL reset_write_bus: got %h want 0", {bus.write_row, bus.write_col, bus.write_char}); else passes++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    int bad;
    exp_q.delete(); obs_q.delete();
    bus.in_valid = 1'b1; bus.in_char = 8'h41;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.write_ce !== 1'b1) $display("FAIL basic_latency_ce: got %b want 1", bus.write_ce); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL basic_latency_ready: got %b want 0", bus.in_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", bus.in_ready); else passes++;
    send_char(8'h42);
    wait_idle(10, 0, ok);
    exp_q.push_back({5'd0, 7'd0, 8'h41});
    exp_q.push_back({5'd0, 7'd1, 8'h42});
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0) $display("FAIL basic_data: got %0d bad entries want 0", bad); else passes++;
    checks++; if (cursor_col !== 7'd2) $display("FAIL basic_col: got %0d want 2", cursor_col); else passes++;
  endtask

  task automatic test_busy();
    int viol;
    exp_q.delete(); obs_q.delete();
    viol = 0;
    bus.vram_busy = 1'b1;
    send_char(8'h58);
    repeat (10) begin
      @(negedge clk);
      if (bus.write_ce !== 1'b0 || bus.in_ready !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    checks++; if (viol !== 0) $display("FAIL busy_hold: got %0d bad cycles want 0", viol); else passes++;
    bus.vram_busy = 1'b0;
    @(negedge clk);
    checks++; if ({bus.write_ce, bus.write_col, bus.write_char} !== {1'b1, 7'd2, 8'h58}) $display("FAIL busy_release: got ce=%b col=%0d ch=%h want 1/2/58", bus.write_ce, bus.write_col, bus.write_char); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL busy_ready: got %b want 1", bus.in_ready); else passes++;
    checks++; if (obs_q.size() !== 1) $display("FAIL busy_count: got %0d want 1", obs_q.size()); else passes++;
    checks++; if (cursor_col !== 7'd3) $display("FAIL busy_col: got %0d want 3", cursor_col); else passes++;
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    logic [7:0] c;
    send_char(8'h0D);
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < COLS; i++) begin
      c = 8'h21 + 8'(i % 90);
      exp_q.push_back({5'd0, 7'(i), c});
      send_char(c);
    end
    wait_idle(10, 0, ok);
    checks++; if (obs_q.size() !== COLS) $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), COLS); else passes++;
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0) $display("FAIL wrap_data: got %0d bad entries want 0", bad); else passes++;
    checks++; if ({cursor_row, cursor_col} !== {5'd1, 7'd0}) $display("FAIL wrap_cursor: got (%0d,%0d) want (1,0)", cursor_row, cursor_col); else passes++;
  endtask

  task automatic test_controls();
    bit ok;
    int bad;
    exp_q.delete(); obs_q.delete();
    send_char(8'h68); send_char(8'h65); send_char(8'h6C); send_char(8'h6C); send_char(8'h6F);
    wait_idle(10, 0, ok);
    exp_q.push_back({5'd1, 7'd0, 8'h68}); exp_q.push_back({5'd1, 7'd1, 8'h65});
    exp_q.push_back({5'd1, 7'd2, 8'h6C}); exp_q.push_back({5'd1, 7'd3, 8'h6C});
    exp_q.push_back({5'd1, 7'd4, 8'h6F});
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0 || obs_q.size() !== 5) $display("FAIL ctl_hello: got %0d bad of %0d want 0 of 5", bad, obs_q.size()); else passes++;
    checks++; if (cursor_col !== 7'd5) $display("FAIL ctl_col5: got %0d want 5", cursor_col); else passes++;
    obs_q.delete();
    send_char(8'h09);
    checks++; if (cursor_col !== 7'd8) $display("FAIL ctl_tab: got %0d want 8", cursor_col); else passes++;
    send_char(8'h08);
    checks++; if (cursor_col !== 7'd7) $display("FAIL ctl_bs: got %0d want 7", cursor_col); else passes++;
    send_char(8'h0D);
    checks++; if (cursor_col !== 7'd0) $display("FAIL ctl_cr: got %0d want 0", cursor_col); else passes++;
    send_char(8'h08);
    checks++; if (cursor_col !== 7'd0) $display("FAIL ctl_bs0: got %0d want 0", cursor_col); else passes++;
    send_char(8'h01);
    checks++; if ({cursor_row, cursor_col} !== {5'd1, 7'd0}) $display("FAIL ctl_ignore: got (%0d,%0d) want (1,0)", cursor_row, cursor_col); else passes++;
    repeat (12) send_char(8'h09);
    checks++; if (cursor_col !== 7'd96) $display("FAIL ctl_tab96: got %0d want 96", cursor_col); else passes++;
    send_char(8'h09);
    checks++; if ({cursor_row, cursor_col} !== {5'd2, 7'd0}) $display("FAIL ctl_tab_wrap: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); else passes++;
    checks++; if (obs_q.size() !== 0) $display("FAIL ctl_no_writes: got %0d want 0", obs_q.size()); else passes++;
  endtask

  task automatic test_scroll();
    bit ok;
    int bad;
    obs_q.delete(); exp_q.delete();
    repeat (27) send_char(8'h0A);
    checks++; if ({top_row, cursor_row, cursor_col} !== {5'd0, 5'd29, 7'd0}) $display("FAIL scroll_pre: got top=%0d (%0d,%0d) want 0 (29,0)", top_row, cursor_row, cursor_col); else passes++;
    checks++; if (obs_q.size() !== 0) $display("FAIL scroll_pre_writes: got %0d want 0", obs_q.size()); else passes++;
    send_char(8'h0A);
    checks++; if ({bus.in_ready, dbg_state} !== {1'b0, 2'd2}) $display("FAIL scroll_clear_state: got ready=%b st=%0d want 0/2", bus.in_ready, dbg_state); else passes++;
    checks++; if ({top_row, cursor_row, cursor_col} !== {5'd1, 5'd29, 7'd0}) $display("FAIL scroll_final_early: got top=%0d (%0d,%0d) want 1 (29,0)", top_row, cursor_row, cursor_col); else passes++;
    wait_idle(600, 1, ok);
    checks++; if (!ok) $display("FAIL scroll_timeout: got no idle want idle within 600 cycles"); else passes++;
    for (int c = 0; c < COLS; c++) exp_q.push_back({5'd0, 7'(c), 8'h20});
    checks++; if (obs_q.size() !== COLS) $display("FAIL scroll_count: got %0d want %0d", obs_q.size(), COLS); else passes++;
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0) $display("FAIL scroll_data: got %0d bad entries want 0", bad); else passes++;
    checks++; if (busy_viol !== 0) $display("FAIL scroll_busy_write: got %0d want 0", busy_viol); else passes++;
    obs_q.delete();
    send_char(8'h5A);
    wait_idle(10, 0, ok);
    checks++; if (obs_q.size() !== 1 || obs_q[0] !== {5'd0, 7'd0, 8'h5A}) $display("FAIL scroll_phys_row: got %0d writes first %h want 1 write 0005a", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'd0); else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    obs_q.delete(); exp_q.delete();
    send_char(8'h71); send_char(8'h72); send_char(8'h73);
    wait_idle(10, 0, ok);
    exp_q.push_back({5'd0, 7'd1, 8'h71});
    exp_q.push_back({5'd0, 7'd2, 8'h72});
    exp_q.push_back({5'd0, 7'd3, 8'h73});
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0 || obs_q.size() !== 3) $display("FAIL b2b_data: got %0d bad of %0d want 0 of 3", bad, obs_q.size()); else passes++;
    checks++; if ({cursor_row, cursor_col} !== {5'd29, 7'd4}) $display("FAIL b2b_cursor: got (%0d,%0d) want (29,4)", cursor_row, cursor_col); else passes++;
  endtask

  task automatic test_ff();
    bit ok;
    int bad;
    repeat (6) begin
      send_char(8'h0A);
      wait_idle(200, 0, ok);
    end
    checks++; if ({top_row, cursor_row} !== {5'd7, 5'd29}) $display("FAIL ff_pre_top: got top=%0d row=%0d want 7/29", top_row, cursor_row); else passes++;
    obs_q.delete(); exp_q.delete();
    busy_viol = 0;
    send_char(8'h0C);
    checks++; if ({bus.in_ready, top_row, cursor_row, cursor_col} !== 18'd0) $display("FAIL ff_early: got ready=%b top=%0d (%0d,%0d) want 0 0 (0,0)", bus.in_ready, top_row, cursor_row, cursor_col); else passes++;
    wait_idle(6000, 1, ok);
    checks++; if (!ok) $display("FAIL ff_timeout: got no idle want idle within 6000 cycles"); else passes++;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back({5'(r), 7'(c), 8'h20});
    checks++; if (obs_q.size() !== ROWS * COLS) $display("FAIL ff_count: got %0d want %0d", obs_q.size(), ROWS * COLS); else passes++;
    bad = 0;
    foreach (exp_q[k]) if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++; if (bad !== 0) $display("FAIL ff_data: got %0d bad entries want 0", bad); else passes++;
    checks++; if (busy_viol !== 0) $display("FAIL ff_busy_write: got %0d want 0", busy_viol); else passes++;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    send_char(8'h41);
    send_char(8'h0C);
    repeat (60) begin
      @(posedge clk); #1;
    end
    checks++; if (dbg_state !== 2'd2) $display("FAIL rst_mid_pre: got state %0d want 2", dbg_state); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({dbg_state, bus.in_ready, bus.write_ce} !== {2'd0, 1'b1, 1'b0}) $display("FAIL rst_mid_ctrl: got st=%0d ready=%b ce=%b want 0/1/0", dbg_state, bus.in_ready, bus.write_ce); else passes++;
    checks++; if ({bus.write_row, bus.write_col, bus.write_char} !== 20'd0) $display("FAIL rst_mid_bus: got %h want 0", {bus.write_row, bus.write_col, bus.write_char}); else passes++;
    checks++; if ({top_row, cursor_row, cursor_col} !== 17'd0) $display("FAIL rst_mid_cursor: got top=%0d (%0d,%0d) want 0 (0,0)", top_row, cursor_row, cursor_col); else passes++;
    n = obs_q.size();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++; if (obs_q.size() !== n) $display("FAIL rst_mid_quiet: got %0d extra writes want 0", obs_q.size() - n); else passes++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.vram_busy = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_wrap();
    test_controls();
    test_scroll();
    test_back_to_back();
    test_ff();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
